rc4_key_search_sequencer: RTL
=============================

RC4_KEY_SEARCH_SEQUENCER -- requirements
Module: rc4_key_search_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RAM_WIDTH, 8, bits per key byte.
- KEY_LENGTH, 3, key bytes.
- KEY_MAX, 24'h3FFFFF, last key value tried (inclusive).
- GUARD, 2, cycles after phase entry during which finished is ignored.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a search.
- abort  in  1  one-cycle pulse that cancels a search.
- finished  in  3  phase-done flags: [0] init, [1] shuffle, [2] decrypt.
- decrypt_ok  in  1  decrypt result; sampled only with finished[2].
- mode  out  3  phase select: 000 none, 001 init, 010 shuffle, 100 decrypt.
- key  out  KEY_LENGTH*RAM_WIDTH  current candidate key; byte 0 is the MSB byte.
- busy  out  1  search in progress.
- found  out  1  key holds a valid key.
- exhausted  out  1  all keys tried, none found.
- attempts  out  KEY_LENGTH*RAM_WIDTH  count of completed decrypt phases.

Function
REQ-003 The state machine SHALL have states IDLE, INIT, SHUF, DECR, GAP, DONE, FAIL, all driven by registered outputs.
REQ-004 mode SHALL be 001 in INIT, 010 in SHUF, 100 in DECR, and 000 in every other state.
REQ-005 In IDLE, DONE or FAIL, a start pulse SHALL on the next edge:
- clear key, attempts, found and exhausted to 0;
- set busy=1;
- enter INIT.
REQ-006 start SHALL be ignored while busy=1.
REQ-007 On entry to INIT, SHUF or DECR, a guard counter SHALL load GUARD; the finished bit for that phase SHALL be ignored until the counter reaches 0, which masks stale finished levels.
REQ-008 After the guard expires:
- INIT with finished[0]=1 SHALL go to GAP with next phase SHUF;
- SHUF with finished[1]=1 SHALL go to GAP with next phase DECR.
REQ-009 GAP SHALL last exactly one cycle with mode=000 and then enter the stored next phase, so the downstream phase sees a mode change and restarts.
REQ-010 In DECR, with the guard expired and finished[2]=1, the block SHALL increment attempts and branch on decrypt_ok:
- decrypt_ok=1: enter DONE, set found=1, hold key unchanged.
- decrypt_ok=0 and key!=KEY_MAX: increment key by 1, enter GAP with next phase INIT.
- decrypt_ok=0 and key==KEY_MAX: enter FAIL, set exhausted=1; key stays KEY_MAX.
REQ-011 Every phase SHALL wait indefinitely; the block SHALL NOT time out.
REQ-012 The key increment SHALL be an unsigned add of width KEY_LENGTH*RAM_WIDTH and SHALL never wrap, because REQ-010 stops the search at KEY_MAX.
REQ-013 attempts SHALL saturate at all-ones.
REQ-014 busy SHALL be 1 in INIT, SHUF, DECR and GAP, and 0 in all other states.
REQ-015 An abort pulse while busy=1 SHALL on the next edge:
- enter IDLE with mode=000 and busy=0;
- keep key and attempts;
- leave found=0 and exhausted=0.
REQ-016 When start and abort are asserted in the same cycle, abort SHALL win; in IDLE, DONE or FAIL the block SHALL then stay in its current state.
REQ-017 finished bits that do not belong to the current phase SHALL be ignored.
REQ-018 Latency from finished[n] to the next nonzero mode SHALL be 2 cycles: 1 cycle to enter GAP, 1 cycle in GAP.
REQ-019 decrypt_ok SHALL have no effect outside the DECR completion cycle.

Reset
REQ-020 reset=0 sampled at a clk edge SHALL set:
- state to IDLE;
- mode=000, key=0, attempts=0;
- busy=0, found=0, exhausted=0;
- guard counter to 0.
REQ-021 Reset SHALL override start, abort and every in-progress phase, including mid-GAP and mid-DECR.
REQ-022 After reset deasserts, the block SHALL stay in IDLE until a start pulse.

Verification
REQ-023 Directed scenarios, each as stimulus -> required response:
- Reset then start; finished[0], finished[1], finished[2] each answered 5 cycles after mode changes, with decrypt_ok=1 -> mode sequence 001,000,010,000,100,000; found=1; key=0; attempts=1; busy=0.
- finished[0] held high from before start -> INIT does not exit during the GAST guard window; it exits on the first cycle after the guard expires.
- decrypt_ok=0 for keys 0..4 and 1 for key 5 -> 6 full INIT/SHUF/DECR rounds; final key=5; attempts=6; found=1.
- KEY_MAX=3 with decrypt_ok always 0 -> exhausted=1; key=3; attempts=4; found=0; mode=000.
- abort during SHUF with key=2 -> next cycle: IDLE, mode=000, busy=0, key=2; a new start restarts from key=0.
- reset=0 pulsed mid-DECR, plus start and abort asserted together in IDLE -> all outputs at reset values; no state change on the simultaneous start/abort.

Source files
------------

// File: rtl/rc4_key_search_sequencer.sv
// Sequences the init / shuffle / decrypt phases of an RC4 brute-force key search,
// stepping the candidate key until decryption succeeds or the key space is spent.
module rc4_key_search_sequencer #(
  parameter int RAM_WIDTH = 8,
  parameter int KEY_LENGTH = 3,
  parameter logic [KEY_LENGTH*RAM_WIDTH-1:0] KEY_MAX = 24'h3FFFFF,
  parameter int GUARD = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [2:0]                       finished,
  input  logic                             decrypt_ok,
  output logic [2:0]                       mode,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0]  key,
  output logic                             busy,
  output logic                             found,
  output logic                             exhausted,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0]  attempts
);

  localparam int KW = KEY_LENGTH * RAM_WIDTH;
  localparam int GW = (GUARD < 2) ? 1 : $clog2(GUARD + 1);

  typedef enum logic [2:0] {IDLE, INIT, SHUF, DECR, GAP, DONE, FAIL} state_t;

  state_t          state, state_nxt;
  state_t          next_phase, next_phase_nxt;
  logic [GW-1:0]   guard_cnt, guard_nxt;
  logic [KW-1:0]   key_nxt, attempts_nxt;
  logic            found_nxt, exhausted_nxt, busy_nxt;
  logic [2:0]      mode_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      next_phase <= INIT;
      guard_cnt  <= '0;
      key        <= '0;
      attempts   <= '0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      busy       <= 1'b0;
      mode       <= 3'b000;
    end else begin
      state      <= state_nxt;
      next_phase <= next_phase_nxt;
      guard_cnt  <= guard_nxt;
      key        <= key_nxt;
      attempts   <= attempts_nxt;
      found      <= found_nxt;
      exhausted  <= exhausted_nxt;
      busy       <= busy_nxt;
      mode       <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    next_phase_nxt = next_phase;
    guard_nxt      = guard_cnt;
    key_nxt        = key;
    attempts_nxt   = attempts;
    found_nxt      = found;
    exhausted_nxt  = exhausted;
    case (state)
      IDLE, DONE, FAIL: begin
        // abort outranks start even when there is nothing to cancel
        if (start && !abort) begin
          state_nxt     = INIT;
          guard_nxt     = GW'(GUARD);
          key_nxt       = '0;
          attempts_nxt  = '0;
          found_nxt     = 1'b0;
          exhausted_nxt = 1'b0;
        end
      end
      INIT: begin
        if (abort) state_nxt = IDLE;
        else if (guard_cnt != '0) guard_nxt = guard_cnt - 1'b1;
        else if (finished[0]) begin
          state_nxt      = GAP;
          next_phase_nxt = SHUF;
        end
      end
      SHUF: begin
        if (abort) state_nxt = IDLE;
        else if (guard_cnt != '0) guard_nxt = guard_cnt - 1'b1;
        else if (finished[1]) begin
          state_nxt      = GAP;
          next_phase_nxt = DECR;
        end
      end
      DECR: begin
        if (abort) state_nxt = IDLE;
        else if (guard_cnt != '0) guard_nxt = guard_cnt - 1'b1;
        else if (finished[2]) begin
          if (attempts != '1) attempts_nxt = attempts + 1'b1;
          if (decrypt_ok) begin
            state_nxt = DONE;
            found_nxt = 1'b1;
          end else if (key == KEY_MAX) begin
            state_nxt     = FAIL;
            exhausted_nxt = 1'b1;
          end else begin
            key_nxt        = key + 1'b1;
            state_nxt      = GAP;
            next_phase_nxt = INIT;
          end
        end
      end
      GAP: begin
        // one idle-mode cycle so the downstream phase sees mode drop and restarts
        if (abort) state_nxt = IDLE;
        else begin
          state_nxt = next_phase;
          guard_nxt = GW'(GUARD);
        end
      end
      default: state_nxt = IDLE;
    endcase

    mode_nxt = 3'b000;
    busy_nxt = 1'b0;
    case (state_nxt)
      INIT:    begin mode_nxt = 3'b001; busy_nxt = 1'b1; end
      SHUF:    begin mode_nxt = 3'b010; busy_nxt = 1'b1; end
      DECR:    begin mode_nxt = 3'b100; busy_nxt = 1'b1; end
      GAP:     busy_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule
